chase_sequencer: RTL and testbench

Controller that sequences the 7-segment chaser's fade datapath. Owns the step prescaler, the 8-position head path and the fade-decay tick. Issues one "load segment to full brightness" command per step over a valid/ready handshake. Sits between the TinyTapeout input pins (speed/direction/run) and the segment-fade/PWM datapath, which consumes `cmd_seg` and `fade_tick`.

---
 rtl/chase_pkg.sv | 31 +++
 rtl/chase_prescaler.sv | 31 +++
 rtl/chase_sequencer.sv | 148 ++++++++++++++
 tb/tb_chase_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chase_pkg.sv
// Shared types and constants for the 7-segment chase sequencer.
// The head path table maps each of the 8 head positions to a segment index.
package chase_pkg;

  localparam int POS_W = 3;
  localparam int SEG_W = 3;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    ISSUE = 2'd1,
    COUNT = 2'd2,
    IDLE  = 2'd3
  } state_t;

  // Figure-eight style path: a, b, g, e, d, c, g, f
  function automatic logic [SEG_W-1:0] path_seg(input logic [POS_W-1:0] p);
    logic [SEG_W-1:0] s;
    case (p)
      3'd0:    s = 3'd0;
      3'd1:    s = 3'd1;
      3'd2:    s = 3'd6;
      3'd3:    s = 3'd4;
      3'd4:    s = 3'd3;
      3'd5:    s = 3'd2;
      3'd6:    s = 3'd6;
      default: s = 3'd5;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/chase_prescaler.sv
// Step-rate prescaler: counts while enabled, flags a step once the count
// reaches or passes the speed-dependent terminal value.
module chase_prescaler #(
  parameter int STEP_CNT_W = 22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] i_speed,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic       o_step
);

  logic [STEP_CNT_W-1:0] r_cnt;
  logic [STEP_CNT_W-1:0] w_terminal;

  assign w_terminal = {i_speed, {(STEP_CNT_W-3){1'b1}}};
  // >= rather than == so a speed decrease below the running count still fires
  assign o_step     = (r_cnt >= w_terminal);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/chase_sequencer.sv
// Chase controller: step FSM, head position, load-command handshake, fade tick.
// Define CHASE_BOUNCE_EN for ping-pong head motion instead of modulo-8 wrap.
module chase_sequencer
  import chase_pkg::*;
#(
  parameter int STEP_CNT_W = 22,
  parameter int FADE_CNT_W = 22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] speed,
  input  logic       dir,
  input  logic       run,
  input  logic       step_req,
  output logic       cmd_valid,
  output logic [2:0] cmd_seg,
  input  logic       cmd_ready,
  output logic       fade_tick,
  output logic [2:0] pos
);

  logic [2:0]            r_speed_q;
  logic                  r_dir_q;
  logic                  r_run_q;
  logic                  r_step_q;
  logic                  r_step_d;
  state_t                r_state;
  state_t                w_state_next;
  logic [POS_W-1:0]      r_pos;
  logic [POS_W-1:0]      w_pos_next;
  logic [POS_W-1:0]      w_pos_adv;
  logic                  r_cmd_valid;
  logic [SEG_W-1:0]      r_cmd_seg;
  logic [FADE_CNT_W-1:0] r_fade_cnt;
  logic [FADE_CNT_W-1:0] w_fade_next;
  logic                  r_fade_tick;
  logic                  w_fwd;
  logic                  w_advance;
  logic                  w_step;
  logic                  w_step_edge;
  logic                  w_cnt_inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_speed_q <= '0;
      r_dir_q   <= 1'b0;
      r_run_q   <= 1'b0;
      r_step_q  <= 1'b0;
      r_step_d  <= 1'b0;
    end else begin
      r_speed_q <= speed;
      r_dir_q   <= dir;
      r_run_q   <= run;
      r_step_q  <= step_req;
      r_step_d  <= r_step_q;
    end
  end

  assign w_step_edge = r_step_q & ~r_step_d;

`ifdef CHASE_BOUNCE_EN
  logic r_flip;

  assign w_fwd = r_dir_q ^ r_flip;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flip <= 1'b0;
    end else if (w_advance &&
                 ((w_fwd && w_pos_adv == 3'd7) || (!w_fwd && w_pos_adv == 3'd0))) begin
      r_flip <= ~r_flip;
    end
  end
`else
  assign w_fwd = r_dir_q;
`endif

  assign w_pos_adv = w_fwd ? (r_pos + 3'd1) : (r_pos - 3'd1);
  // Count only while running in COUNT; every other state holds the counter at 0
  assign w_cnt_inc = (r_state == COUNT) && r_run_q && !w_step;

  chase_prescaler #(
    .STEP_CNT_W(STEP_CNT_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .i_speed(r_speed_q),
    .i_clr  (~w_cnt_inc),
    .i_inc  (w_cnt_inc),
    .o_step (w_step)
  );

  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    case (r_state)
      INIT:  w_state_next = ISSUE;
      ISSUE: begin
        if (cmd_ready) w_state_next = r_run_q ? COUNT : IDLE;
      end
      COUNT: begin
        if (w_step) begin
          w_advance    = 1'b1;
          w_state_next = ISSUE;
        end else if (!r_run_q) begin
          w_state_next = IDLE;
        end
      end
      IDLE: begin
        if (w_step_edge) begin
          w_advance    = 1'b1;
          w_state_next = ISSUE;
        end else if (r_run_q) begin
          w_state_next = COUNT;
        end
      end
      default: w_state_next = INIT;
    endcase
    w_pos_next = w_advance ? w_pos_adv : r_pos;
    if (r_state == INIT) w_pos_next = '0;
  end

  assign w_fade_next = r_fade_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= INIT;
      r_pos       <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_seg   <= '0;
      r_fade_cnt  <= '0;
      r_fade_tick <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pos       <= w_pos_next;
      r_cmd_valid <= (w_state_next == ISSUE);
      r_cmd_seg   <= path_seg(w_pos_next);
      r_fade_cnt  <= w_fade_next;
      r_fade_tick <= (w_fade_next == '0);
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_seg   = r_cmd_seg;
  assign pos       = r_pos;
  assign fade_tick = r_fade_tick;

endmodule

// File: tb/tb_chase_sequencer.sv
// Randomized self-checking bench for chase_sequencer (STEP_CNT_W=6, FADE_CNT_W=4).
// Reference model tracks head position arithmetically, honouring CHASE_BOUNCE_EN.
module tb_chase_sequencer;

  localparam int STEP_W = 6;
  localparam int FADE_W = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] speed = 3'd0;
  logic       dir = 1'b1;
  logic       run = 1'b1;
  logic       step_req = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [2:0] cmd_seg;
  logic       fade_tick;
  logic [2:0] pos;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int m_pos = 0;
  bit m_flip = 1'b0;
  bit noise_en = 1'b0;
  int fade_n = 0;
  int path_tbl [8] = '{0, 1, 6, 4, 3, 2, 6, 5};

  chase_sequencer #(
    .STEP_CNT_W(STEP_W),
    .FADE_CNT_W(FADE_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .speed    (speed),
    .dir      (dir),
    .run      (run),
    .step_req (step_req),
    .cmd_valid(cmd_valid),
    .cmd_seg  (cmd_seg),
    .cmd_ready(cmd_ready),
    .fade_tick(fade_tick),
    .pos      (pos)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Free-running fade counter: tick whenever the edges since reset release wrap to 0
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      fade_n = 0;
    end else begin
      fade_n++;
      check("fade_tick", int'(fade_tick), int'((fade_n % (1 << FADE_W)) == 0));
    end
  end

  task automatic wait_cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (noise_en) step_req = 1'($urandom_range(0, 1));
  endtask

  function automatic void model_step();
    bit fwd;
`ifdef CHASE_BOUNCE_EN
    fwd = dir ^ m_flip;
`else
    fwd = dir;
`endif
    m_pos = fwd ? (m_pos + 1) % 8 : (m_pos + 7) % 8;
`ifdef CHASE_BOUNCE_EN
    if ((fwd && m_pos == 7) || (!fwd && m_pos == 0)) m_flip = ~m_flip;
`endif
  endfunction

  // Wait for a command, check it, optionally stall, then accept it.
  // gap = edges from the previous acceptance to this command's first valid cycle.
  task automatic serve_cmd(input int stall, input bit timed, input int gap);
    int n = 0;
    while (!cmd_valid && n < 200) begin
      wait_cycle();
      n++;
    end
    check("cmd_wait", int'(cmd_valid), 1);
    check("cmd_pos", int'(pos), m_pos);
    check("cmd_seg", int'(cmd_seg), path_tbl[m_pos]);
    if (timed) check("step_gap", cyc - acc_cyc, gap);
    for (int i = 0; i < stall; i++) begin
      wait_cycle();
      check("stall_valid", int'(cmd_valid), 1);
      check("stall_pos", int'(pos), m_pos);
      check("stall_seg", int'(cmd_seg), path_tbl[m_pos]);
    end
    cmd_ready = 1'b1;
    wait_cycle();
    acc_cyc = cyc;
    cmd_ready = 1'b0;
    check("accept_drop", int'(cmd_valid), 0);
  endtask

  task automatic pause_dut();
    int nval = 0;
    noise_en = 1'b0;
    step_req = 1'b0;
    repeat (3) wait_cycle();
    run = 1'b0;
    repeat (30) begin
      wait_cycle();
      if (cmd_valid) nval++;
    end
    check("paused_quiet", nval, 0);
  endtask

  task automatic pulse_step();
    step_req = 1'b1;
    wait_cycle();
    step_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int spd;
    int nsteps;
    int nval;
    int n;

    repeat (3) wait_cycle();
    check("rst_valid", int'(cmd_valid), 0);
    check("rst_pos", int'(pos), 0);
    check("rst_seg", int'(cmd_seg), 0);
    check("rst_fade", int'(fade_tick), 0);
    #2 reset = 1'b1;

    // Free run forward at speed 0, one long stall mid-sequence
    serve_cmd(0, 1'b0, 0);
    for (int i = 1; i <= 9; i++) begin
      model_step();
      serve_cmd((i == 3) ? 20 : 0, 1'b1, 8);
    end

    // Paused single steps, backward through position 0
    pause_dut();
    dir = 1'b0;
    repeat (2) wait_cycle();
    pulse_step();
    model_step();
    serve_cmd(5, 1'b0, 0);
    repeat (5) wait_cycle();
    pulse_step();
    model_step();
    serve_cmd(0, 1'b0, 0);

    // A held-high request is a single rising edge
    dir = 1'b1;
    repeat (2) wait_cycle();
    cmd_ready = 1'b1;
    step_req = 1'b1;
    nval = 0;
    repeat (30) begin
      wait_cycle();
      if (cmd_valid) nval++;
    end
    model_step();
    check("held_req_count", nval, 1);
    check("held_req_pos", int'(pos), m_pos);
    step_req = 1'b0;
    cmd_ready = 1'b0;
    repeat (2) wait_cycle();

    // Random running phases with random stalls and ignored step_req noise
    for (int ph = 0; ph < 6; ph++) begin
      pause_dut();
      spd = $urandom_range(0, 1);
      nsteps = $urandom_range(3, 8);
      speed = 3'(spd);
      dir = 1'($urandom_range(0, 1));
      repeat (2) wait_cycle();
      run = 1'b1;
      noise_en = 1'b1;
      model_step();
      serve_cmd($urandom_range(0, 3), 1'b0, 0);
      for (int s = 1; s < nsteps; s++) begin
        model_step();
        serve_cmd(($urandom_range(0, 7) == 0) ? 12 : $urandom_range(0, 3),
                  1'b1, spd * 8 + 8);
      end
    end

    // Drop speed 7 -> 0 with the counter at 40: step two edges later
    pause_dut();
    speed = 3'd7;
    dir = 1'b1;
    repeat (2) wait_cycle();
    run = 1'b1;
    model_step();
    serve_cmd(0, 1'b0, 0);
    repeat (40) wait_cycle();
    check("slow_hold", int'(cmd_valid), 0);
    speed = 3'd0;
    n = 0;
    while (!cmd_valid && n < 10) begin
      wait_cycle();
      n++;
    end
    check("speed_drop_lat", n, 2);
    model_step();
    serve_cmd(0, 1'b0, 0);

    // Reset while a command is pending
    n = 0;
    while (!cmd_valid && n < 50) begin
      wait_cycle();
      n++;
    end
    check("pre_rst_valid", int'(cmd_valid), 1);
    #2 reset = 1'b0;
    #1;
    check("midrst_valid", int'(cmd_valid), 0);
    check("midrst_pos", int'(pos), 0);
    check("midrst_seg", int'(cmd_seg), 0);
    check("midrst_fade", int'(fade_tick), 0);
    repeat (2) wait_cycle();
    #2 reset = 1'b1;
    m_pos = 0;
    m_flip = 1'b0;
    serve_cmd(0, 1'b0, 0);
    model_step();
    serve_cmd(0, 1'b1, 8);

    repeat (5) wait_cycle();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
